lb_32x128_fifo_ctrl: RTL

- Streaming FIFO controller that drives a 32x128 line-buffer macro through its R0 (read) and W0 (write) ports; this block is the master side of that port pair.
- Accepts 128-bit beats on a valid/ready input, writes them into the macro, and prefetches them back out into a 2-entry output stage with a valid/ready output.
- Sits between a line producer and consumer; full 1-beat/cycle throughput in both directions.

---
 rtl/lb_32x128_fifo_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/lb_32x128_fifo_ctrl.sv
// Line-buffer FIFO controller: writes beats into a 32x128 macro and prefetches them into a 2-entry output stage.
// Latency accept->out_valid 2 cycles (capture bypasses to out_data); backpressure holds head, stalls reads, in_ready=0 when macro full.
module lb_32x128_fifo_ctrl #(
   parameter int DEPTH  = 32,
   parameter int WIDTH  = 128,
   parameter int ADDR_W = 5
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  out_data,
   output logic [5:0]        level,
   output logic [ADDR_W-1:0] R0_addr,
   output logic              R0_en,
   output logic              R0_clk,
   input  logic [WIDTH-1:0]  R0_data,
   output logic [ADDR_W-1:0] W0_addr,
   output logic              W0_en,
   output logic              W0_clk,
   output logic [WIDTH-1:0]  W0_data
);
   localparam int CNT_W = ADDR_W + 1;

   logic [ADDR_W-1:0] wptr_q, wptr_d;
   logic [ADDR_W-1:0] rptr_q, rptr_d;
   logic [CNT_W-1:0]  mem_cnt_q, mem_cnt_d;
   logic [CNT_W-1:0]  avail_q, avail_d;
   logic              inflight_q, inflight_d;
   logic [1:0]        occ_q, occ_d;
   logic [WIDTH-1:0]  head_q, head_d;
   logic [WIDTH-1:0]  skid_q, skid_d;

   logic              wr;
   logic              pop;
   logic              pop_stage;
   logic              cap_push;
   logic              rd_issue;
   logic [2:0]        pend;
   logic [1:0]        wr_idx;

   assign R0_clk  = clock;
   assign W0_clk  = clock;
   assign W0_data = in_data;

   assign in_ready  = !reset && (mem_cnt_q < CNT_W'(DEPTH));
   assign out_valid = !reset && ((occ_q != 2'd0) || inflight_q);
   // With the stage empty, the beat being captured is presented straight from the macro.
   assign out_data  = (occ_q != 2'd0) ? head_q : R0_data;
   assign level     = reset ? 6'd0 : 6'(mem_cnt_q + CNT_W'(occ_q));

   assign wr        = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign pop_stage = pop && (occ_q != 2'd0);
   // A captured beat that is popped in the same cycle via the bypass never enters the stage.
   assign cap_push  = inflight_q && !(pop && (occ_q == 2'd0));

   // Beats the output stage will still hold after this cycle's pop, counting the in-flight read.
   assign pend      = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign rd_issue  = !reset && (avail_q != '0) && (pend < 3'd2);
   assign wr_idx    = occ_q - {1'b0, pop_stage};

   assign W0_en   = wr;
   assign W0_addr = wptr_q;
   assign R0_en   = rd_issue;
   assign R0_addr = rptr_q;

   always_comb begin
      wptr_d     = wptr_q + ADDR_W'(wr);
      rptr_d     = rptr_q + ADDR_W'(rd_issue);
      mem_cnt_d  = mem_cnt_q + CNT_W'(wr) - CNT_W'(inflight_q);
      avail_d    = avail_q + CNT_W'(wr) - CNT_W'(rd_issue);
      inflight_d = rd_issue;
      occ_d      = occ_q - {1'b0, pop_stage} + {1'b0, cap_push};
      head_d     = head_q;
      skid_d     = skid_q;
      if (pop_stage) begin
         head_d = skid_q;
      end
      if (cap_push) begin
         if (wr_idx == 2'd0) begin
            head_d = R0_data;
         end else begin
            skid_d = R0_data;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         mem_cnt_q  <= '0;
         avail_q    <= '0;
         inflight_q <= 1'b0;
         occ_q      <= 2'd0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         mem_cnt_q  <= mem_cnt_d;
         avail_q    <= avail_d;
         inflight_q <= inflight_d;
         occ_q      <= occ_d;
      end
   end

   always_ff @(posedge clock) begin
      head_q <= head_d;
      skid_q <= skid_d;
   end

endmodule
